// File: rtl/vec_pkg.sv
// Shared types for the vector execution controller: opcodes, FSM states,
// error codes and small opcode helpers.
package vec_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_MOV = 4'd6,
        OP_NOT = 4'd7
    } vop_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LEN   = 3'd2,
        S_EXEC  = 3'd3,
        S_WRITE = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    // MOV and NOT only consume operand A.
    function automatic logic is_unary(vop_t op);
        return (op == OP_MOV) || (op == OP_NOT);
    endfunction

    // Opcodes outside the defined set behave as NOP.
    function automatic vop_t decode_op(logic [3:0] raw);
        return (raw <= 4'd7) ? vop_t'(raw) : OP_NOP;
    endfunction

endpackage

// File: rtl/vec_exec_ctrl.sv
// Single-instruction sequencer over the vector register bank and ALU:
// accept, read operands, resolve length, run the ALU, write back, report.
//
// Instruction handshake: an instruction transfers on a rising edge where
// instr_valid && instr_ready. instr_ready is high only in IDLE and drops the
// cycle after a transfer; the front-end holds instr_valid and the fields
// stable until the transfer. instr_valid while busy is ignored.
module vec_exec_ctrl
    import vec_pkg::*;
#(
    parameter int N       = 4,
    parameter int LEN_W   = 8,
    parameter int SEL_W   = 4,
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [3:0]       instr_op,
    input  logic [SEL_W-1:0] instr_dst,
    input  logic [SEL_W-1:0] instr_src_a,
    input  logic [SEL_W-1:0] instr_src_b,
    output logic [SEL_W-1:0] bank_out_sel_a,
    output logic [SEL_W-1:0] bank_out_sel_b,
    output logic             bank_out_en_a,
    output logic             bank_out_en_b,
    input  logic [LEN_W-1:0] bank_a_len,
    input  logic [LEN_W-1:0] bank_b_len,
    output logic [SEL_W-1:0] bank_in_sel,
    output logic [LEN_W-1:0] bank_in_len,
    output logic             bank_write,
    output logic [3:0]       alu_op,
    output logic             alu_start,
    input  logic             alu_done,
    output logic             busy,
    output logic             done,
    output logic [1:0]       err,
    output logic [2:0]       dbg_state
);

    localparam int RD_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [RD_W-1:0]  RD_LOAD  = RD_W'(RD_LAT - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [LEN_W-1:0] N_LEN    = LEN_W'(N);

    state_t           state_q, state_d;
    vop_t             op_q;
    vop_t             alu_op_q;
    logic [SEL_W-1:0] dst_q;
    logic [LEN_W-1:0] len_q, len_d;
    logic             mis_q, mis_d;
    logic [1:0]       fin_err_d;
    logic [RD_W-1:0]  rd_cnt_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic [LEN_W-1:0] a_cap;

    logic             instr_ready_q, busy_q, done_q;
    logic [1:0]       err_q;
    logic [SEL_W-1:0] sel_a_q, sel_b_q, in_sel_q;
    logic             en_a_q, en_b_q, write_q, start_q;
    logic [LEN_W-1:0] in_len_q;

    // Next state, effective length and the error reported on entry to FIN.
    always_comb begin
        state_d   = state_q;
        fin_err_d = ERR_NONE;
        a_cap     = (bank_a_len > N_LEN) ? N_LEN : bank_a_len;
        len_d     = a_cap;
        if (!is_unary(op_q) && (bank_b_len < a_cap)) begin
            len_d = bank_b_len;
        end
        mis_d = (op_q != OP_NOP) && !is_unary(op_q) && (bank_a_len != bank_b_len);
        case (state_q)
            S_IDLE:  if (instr_valid) state_d = S_READ;
            S_READ:  if (rd_cnt_q == '0) state_d = S_LEN;
            S_LEN: begin
                if ((op_q == OP_NOP) || (len_d == '0)) begin
                    state_d   = S_FIN;
                    fin_err_d = mis_d ? ERR_LEN : ERR_NONE;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // A done arriving on the last allowed cycle beats the timeout.
                if (alu_done) begin
                    state_d = S_WRITE;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d   = S_FIN;
                    fin_err_d = ERR_TIMEOUT;
                end
            end
            S_WRITE: begin
                state_d   = S_FIN;
                fin_err_d = mis_q ? ERR_LEN : ERR_NONE;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state, counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            op_q          <= OP_NOP;
            alu_op_q      <= OP_NOP;
            dst_q         <= '0;
            len_q         <= '0;
            mis_q         <= 1'b0;
            rd_cnt_q      <= '0;
            to_cnt_q      <= '0;
            instr_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= ERR_NONE;
            sel_a_q       <= '0;
            sel_b_q       <= '0;
            en_a_q        <= 1'b0;
            en_b_q        <= 1'b0;
            in_sel_q      <= '0;
            in_len_q      <= '0;
            write_q       <= 1'b0;
            start_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= 1'b0;
            write_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= ERR_NONE;
            case (state_q)
                S_IDLE: begin
                    if (instr_valid) begin
                        op_q          <= decode_op(instr_op);
                        dst_q         <= instr_dst;
                        sel_a_q       <= instr_src_a;
                        en_a_q        <= 1'b1;
                        sel_b_q       <= is_unary(decode_op(instr_op)) ? '0 : instr_src_b;
                        en_b_q        <= !is_unary(decode_op(instr_op));
                        rd_cnt_q      <= RD_LOAD;
                        mis_q         <= 1'b0;
                        instr_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                    end
                end
                S_READ: begin
                    if (rd_cnt_q != '0) rd_cnt_q <= rd_cnt_q - 1'b1;
                end
                S_LEN: begin
                    len_q <= len_d;
                    mis_q <= mis_d;
                    if (state_d == S_EXEC) begin
                        start_q  <= 1'b1;
                        alu_op_q <= op_q;
                        to_cnt_q <= '0;
                    end
                end
                S_EXEC: begin
                    if (state_d == S_WRITE) begin
                        write_q  <= 1'b1;
                        in_sel_q <= dst_q;
                        in_len_q <= len_q;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                S_FIN: begin
                    instr_ready_q <= 1'b1;
                    busy_q        <= 1'b0;
                end
                default: ;
            endcase
            // Entering FIN: report, and release every bank/ALU control.
            if ((state_d == S_FIN) && (state_q != S_FIN)) begin
                done_q   <= 1'b1;
                err_q    <= fin_err_d;
                en_a_q   <= 1'b0;
                en_b_q   <= 1'b0;
                sel_a_q  <= '0;
                sel_b_q  <= '0;
                in_sel_q <= '0;
                in_len_q <= '0;
                alu_op_q <= OP_NOP;
            end
        end
    end

    assign instr_ready    = instr_ready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign bank_out_sel_a = sel_a_q;
    assign bank_out_sel_b = sel_b_q;
    assign bank_out_en_a  = en_a_q;
    assign bank_out_en_b  = en_b_q;
    assign bank_in_sel    = in_sel_q;
    assign bank_in_len    = in_len_q;
    assign bank_write     = write_q;
    assign alu_start      = start_q;
    assign alu_op         = alu_op_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_vec_exec_ctrl.sv
// Bench for vec_exec_ctrl: register-length bank model, delay-programmable
// ALU model, scoreboard of expected write-backs and completions.
module tb_vec_exec_ctrl;

    localparam int N       = 4;
    localparam int LEN_W   = 8;
    localparam int SEL_W   = 4;
    localparam int RD_LAT  = 1;
    localparam int TIMEOUT = 8;

    logic             clk, rst;
    logic             instr_valid, instr_ready;
    logic [3:0]       instr_op;
    logic [SEL_W-1:0] instr_dst, instr_src_a, instr_src_b;
    logic [SEL_W-1:0] bank_out_sel_a, bank_out_sel_b, bank_in_sel;
    logic             bank_out_en_a, bank_out_en_b, bank_write;
    logic [LEN_W-1:0] bank_a_len, bank_b_len, bank_in_len;
    logic [3:0]       alu_op;
    logic             alu_start, alu_done, busy, done;
    logic [1:0]       err;
    logic [2:0]       dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int start_cnt = 0;
    int alu_lat_cfg = 0;
    int alu_cd = 0;
    logic [3:0] cur_op = 4'd0;

    logic [LEN_W-1:0] reg_len [16];
    logic [SEL_W+LEN_W-1:0] exp_wr_q[$];
    logic [33:0] exp_done_q[$];

    vec_exec_ctrl #(.N(N), .LEN_W(LEN_W), .SEL_W(SEL_W), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
        .instr_dst(instr_dst), .instr_src_a(instr_src_a), .instr_src_b(instr_src_b),
        .bank_out_sel_a(bank_out_sel_a), .bank_out_sel_b(bank_out_sel_b),
        .bank_out_en_a(bank_out_en_a), .bank_out_en_b(bank_out_en_b),
        .bank_a_len(bank_a_len), .bank_b_len(bank_b_len),
        .bank_in_sel(bank_in_sel), .bank_in_len(bank_in_len), .bank_write(bank_write),
        .alu_op(alu_op), .alu_start(alu_start), .alu_done(alu_done),
        .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
    );

    // Clock and cycle counter.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    // Bank model: lengths valid one cycle after the select.
    always @(posedge clk) begin
        bank_a_len <= bank_out_en_a ? reg_len[bank_out_sel_a] : '0;
        bank_b_len <= bank_out_en_b ? reg_len[bank_out_sel_b] : '0;
    end

    // ALU model: done on the alu_lat_cfg-th cycle counting the start cycle; 0 = never.
    always @(negedge clk) begin
        alu_done = 1'b0;
        if (rst) begin
            alu_cd = 0;
        end else begin
            if (alu_start && alu_lat_cfg > 0) alu_cd = alu_lat_cfg;
            if (alu_cd > 0) begin
                alu_cd = alu_cd - 1;
                if (alu_cd == 0) alu_done = 1'b1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: pop expected write-backs and completions as the DUT produces them.
    always @(negedge clk) begin
        logic [SEL_W+LEN_W-1:0] ew;
        logic [33:0] ed;
        if (!rst) begin
            if (bank_write) begin
                check_eq("write_pending", 32'(exp_wr_q.size() != 0), 32'd1);
                if (exp_wr_q.size() != 0) begin
                    ew = exp_wr_q.pop_front();
                    check_eq("write_sel_len", 32'({bank_in_sel, bank_in_len}), 32'(ew));
                end
            end
            if (done) begin
                check_eq("done_pending", 32'(exp_done_q.size() != 0), 32'd1);
                if (exp_done_q.size() != 0) begin
                    ed = exp_done_q.pop_front();
                    check_eq("done_err", 32'(err), 32'(ed[33:32]));
                    check_eq("done_cycle", 32'(cyc), ed[31:0]);
                end
            end
            if (alu_start) begin
                start_cnt = start_cnt + 1;
                check_eq("alu_op", 32'(alu_op), 32'(cur_op));
            end
        end
    end

    task automatic wait_ready(input string tag);
        int w = 0;
        while (!instr_ready && w < 400) begin
            @(negedge clk);
            w++;
        end
        check_eq(tag, 32'(instr_ready), 32'd1);
    endtask

    // Issue one instruction; lat = ALU cycles counting the start cycle, 0 = never done.
    task automatic run_instr(input logic [3:0] op, input logic [SEL_W-1:0] d,
                             input logic [SEL_W-1:0] sa, input logic [SEL_W-1:0] sb,
                             input int lat);
        logic known, unary, mis, wr;
        int la, lb, len, latency, s0;
        logic [1:0] e;
        known = (op <= 4'd7);
        unary = known && (op == 4'd6 || op == 4'd7);
        la = int'(reg_len[sa]);
        lb = int'(reg_len[sb]);
        len = (la < N) ? la : N;
        if (!unary && lb < len) len = lb;
        mis = known && (op != 4'd0) && !unary && (la != lb);
        if (!known || op == 4'd0 || len == 0) begin
            wr = 1'b0; e = mis ? 2'd1 : 2'd0; latency = RD_LAT + 2;
        end else if (lat < 1 || lat > TIMEOUT) begin
            wr = 1'b0; e = 2'd2; latency = RD_LAT + 2 + TIMEOUT;
        end else begin
            wr = 1'b1; e = mis ? 2'd1 : 2'd0; latency = RD_LAT + 3 + lat;
        end
        wait_ready("ready_before_issue");
        alu_lat_cfg = lat;
        cur_op = known ? op : 4'd0;
        s0 = start_cnt;
        instr_op = op; instr_dst = d; instr_src_a = sa; instr_src_b = sb;
        instr_valid = 1'b1;
        exp_done_q.push_back({e, 32'(cyc + latency)});
        if (wr) exp_wr_q.push_back({d, LEN_W'(len)});
        @(negedge clk);
        instr_valid = 1'b0;
        instr_op = 4'($urandom_range(0, 15));
        instr_src_a = SEL_W'($urandom_range(0, 15));
        check_eq("read_sel_a", 32'(bank_out_sel_a), 32'(sa));
        check_eq("read_sel_b", 32'(bank_out_sel_b), unary ? 32'd0 : 32'(sb));
        check_eq("read_en_a", 32'(bank_out_en_a), 32'd1);
        check_eq("read_en_b", 32'(bank_out_en_b), unary ? 32'd0 : 32'd1);
        check_eq("ready_low", 32'(instr_ready), 32'd0);
        check_eq("busy_high", 32'(busy), 32'd1);
        wait_ready("return_idle");
        check_eq("done_arrived", 32'(exp_done_q.size()), 32'd0);
        check_eq("write_arrived", 32'(exp_wr_q.size()), 32'd0);
        check_eq("start_count", 32'(start_cnt - s0), (wr || e == 2'd2) ? 32'd1 : 32'd0);
        exp_done_q.delete();
        exp_wr_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_ready"}, 32'(instr_ready), 32'd1);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_ctrl"}, 32'({bank_out_en_a, bank_out_en_b, bank_write, alu_start, done}), 32'd0);
        check_eq({tag, "_sels"}, 32'({bank_out_sel_a, bank_out_sel_b, bank_in_sel}), 32'd0);
        check_eq({tag, "_len_op_err"}, 32'({bank_in_len, alu_op, err}), 32'd0);
        check_eq({tag, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    initial begin
        int w;
        for (int i = 0; i < 16; i++) reg_len[i] = '0;
        reg_len[0] = 8'd3; reg_len[1] = 8'd3; reg_len[2] = 8'd5; reg_len[3] = 8'd2;
        reg_len[4] = 8'd0; reg_len[5] = 8'd7; reg_len[6] = 8'd6; reg_len[7] = 8'd4;
        reg_len[8] = 8'd0; reg_len[9] = 8'd1;
        rst = 1'b1; instr_valid = 1'b0; instr_op = '0;
        instr_dst = '0; instr_src_a = '0; instr_src_b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");

        run_instr(4'd1, 4'd2, 4'd1, 4'd0, 2);        // ADD, equal lengths
        run_instr(4'd1, 4'd2, 4'd3, 4'd0, 2);        // ADD, length mismatch
        run_instr(4'd7, 4'd2, 4'd1, 4'd5, 1);        // NOT, B ignored
        run_instr(4'd0, 4'd2, 4'd1, 4'd0, 2);        // NOP
        run_instr(4'd1, 4'd2, 4'd4, 4'd8, 2);        // zero length
        run_instr(4'd1, 4'd2, 4'd1, 4'd0, 0);        // ALU never completes
        run_instr(4'd2, 4'd3, 4'd1, 4'd0, TIMEOUT);  // done on the last allowed cycle
        run_instr(4'd4, 4'd6, 4'd5, 4'd6, 3);        // OR, clamp to N, mismatch
        run_instr(4'hC, 4'd2, 4'd1, 4'd0, 2);        // unknown opcode
        run_instr(4'd6, 4'd1, 4'd1, 4'd9, 1);        // MOV, dst == src

        // Reset while waiting on the ALU.
        alu_lat_cfg = 0;
        cur_op = 4'd1;
        instr_op = 4'd1; instr_dst = 4'd2; instr_src_a = 4'd1; instr_src_b = 4'd0;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        w = 0;
        while (dbg_state != 3'd3 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check_eq("reach_exec", 32'(dbg_state), 32'd3);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("mid_reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        run_instr(4'd1, 4'd2, 4'd1, 4'd0, 2);

        for (int k = 0; k < 12; k++) begin
            run_instr(4'($urandom_range(0, 8) == 8 ? 12 : $urandom_range(0, 7)),
                      SEL_W'($urandom_range(0, 15)), SEL_W'($urandom_range(0, 9)),
                      SEL_W'($urandom_range(0, 9)), $urandom_range(1, 4));
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vec_exec_ctrl.md
Name: vec_exec_ctrl

Overview:
- Sequencer for one vector instruction at a time over vec_reg_bank and the vector ALU.
- Accepts an instruction (op, dst, src_a, src_b) on a valid/ready handshake, then runs the full sequence: select and read operands from the bank, start the ALU and wait for completion, write the result back to the bank.
- Sits between the instruction front-end (Python HAL command decoder) and the datapath.
- Owns every bank select, enable and write strobe.

Parameters:
- N, 4: elements per vector register; the bank's max length.
- LEN_W, 8: width of the length fields; matches bank in_len/out_*_len.
- SEL_W, 4: register select width (16 registers).
- RD_LAT, 1: cycles from bank select change to valid out_a/out_b.
- TIMEOUT, 255: max cycles waiting for alu_done before abort.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction presented
- instr_ready  out  1  controller can accept
- instr_op  in  4  opcode (vec_pkg::vop_t)
- instr_dst  in  SEL_W  destination register
- instr_src_a  in  SEL_W  operand A register
- instr_src_b  in  SEL_W  operand B register (ignored for unary ops)
- bank_out_sel_a  out  SEL_W  to bank out_sel_a
- bank_out_sel_b  out  SEL_W  to bank out_sel_b
- bank_out_en_a  out  1  to bank out_en_a
- bank_out_en_b  out  1  to bank out_en_b
- bank_a_len  in  LEN_W  from bank out_a_len
- bank_b_len  in  LEN_W  from bank out_b_len
- bank_in_sel  out  SEL_W  to bank in_sel
- bank_in_len  out  LEN_W  to bank in_len
- bank_write  out  1  to bank write, one-cycle strobe
- alu_op  out  4  opcode to ALU, held from EXEC through WRITE
- alu_start  out  1  one-cycle ALU start pulse
- alu_done  in  1  ALU result valid on the bank in bus
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  2  error code, valid only with done: 0 none, 1 length mismatch, 2 timeout

Behaviour:
- Reset: state IDLE. instr_ready=1. All other outputs 0, including all selects, enables, bank_in_len and alu_op.
- States: IDLE, READ, LEN, EXEC, WRITE, FIN.
- IDLE
  - instr_ready=1.
  - On instr_valid: latch op/dst/src_a/src_b and go to READ.
  - instr_ready drops the cycle after acceptance and stays low until the controller returns to IDLE.
- READ
  - Drive bank_out_sel_a/b from the latched registers and assert both out_en.
  - For unary ops, out_en_b=0 and sel_b=0.
  - Hold for RD_LAT cycles using a down-counter, then go to LEN.
  - out_en and selects stay asserted through WRITE.
- LEN (1 cycle)
  - Unary op: len = min(bank_a_len, N).
  - Binary op: len = min(bank_a_len, bank_b_len, N); set err=1 if a_len != b_len. The operation still proceeds using the min.
  - OP_NOP, or len==0: skip to FIN with no ALU start and no write.
  - Otherwise pulse alu_start for 1 cycle and go to EXEC.
- EXEC
  - Wait for alu_done. A timeout counter counts from 0.
  - If the counter reaches TIMEOUT without alu_done: err=2, no write, go to FIN.
  - alu_done in the same cycle as the timeout wins; the write proceeds.
- WRITE (1 cycle)
  - bank_write=1, bank_in_sel=dst, bank_in_len=len. Then go to FIN.
  - dst equal to a source register is legal: the operands were already consumed by the ALU.
- FIN (1 cycle)
  - done=1 and err valid.
  - Deassert out_en; clear selects, bank_write and alu_op.
  - Return to IDLE. A new instruction is accepted the next cycle, so there is no back-to-back overlap.
- Minimum latency from acceptance to done: 1 + RD_LAT + 1 + (ALU cycles) + 1 + 1.
- instr_valid while busy is ignored; the front-end holds it until instr_ready.
- rst mid-instruction: return to IDLE next edge with all outputs at reset values. No write occurs and no done is issued.
- An unknown opcode is treated as OP_NOP.

Decomposition:
- vec_pkg holds:
  - typedef enum logic [3:0] vop_t: OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV, OP_NOT.
  - function is_unary(vop_t), true for MOV and NOT.
  - typedef enum for FSM states.
  - err code localparams.
- No sub-module; a single FSM with two counters (read-latency and timeout).

Test Plan:
- ADD, dst=2, src_a=1 (len 3), src_b=0 (len 3), alu_done 2 cycles after start -> sel_a=1, sel_b=0; alu_start pulses once; bank_write=1 with in_sel=2, in_len=3; done with err=0 six cycles after acceptance.
- ADD with a_len=2, b_len=3 -> bank_in_len=2, write occurs, done with err=1.
- NOT, src_a=1 (len 3), src_b=5 -> out_en_b=0; write in_len=3; err=0.
- NOP, or source len=0 -> no alu_start, no bank_write, done with err=0.
- TIMEOUT=8 with alu_done never asserted -> done 8 cycles after EXEC entry, err=2, bank_write never asserted.
- rst asserted during EXEC -> next cycle instr_ready=1, bank_write=0, no done; a new ADD then completes normally.
